// File: rtl/hpdmc_fmlarb_if.sv
// Bundle of the four FML master ports and the single FML port toward the hpdmc.
// slave = arbiter side, master = requesters plus the memory controller.
interface hpdmc_fmlarb_if #(
  parameter int sdram_depth = 26
);
  logic [4*sdram_depth-1:0] m_adr;
  logic [3:0]               m_stb;
  logic [3:0]               m_we;
  logic [3:0]               m_ack;
  logic [15:0]              m_sel;
  logic [127:0]             m_di;
  logic [31:0]              m_do;

  logic [sdram_depth-1:0]   s_adr;
  logic                     s_stb;
  logic                     s_we;
  logic                     s_ack;
  logic [3:0]               s_sel;
  logic [31:0]              s_di;
  logic [31:0]              s_do;

  modport slave (
    input  m_adr, m_stb, m_we, m_sel, m_di, s_ack, s_do,
    output m_ack, m_do, s_adr, s_stb, s_we, s_sel, s_di
  );

  modport master (
    output m_adr, m_stb, m_we, m_sel, m_di, s_ack, s_do,
    input  m_ack, m_do, s_adr, s_stb, s_we, s_sel, s_di
  );
endinterface

// File: rtl/hpdmc_fmlarb.sv
// Round-robin arbiter of four FML masters onto one hpdmc FML port, 4-beat bursts.
// Grant registered one cycle after a request; pending requests wait for IDLE.
module hpdmc_fmlarb #(
  parameter int sdram_depth = 26
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  hpdmc_fmlarb_if.slave fml
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic [1:0] r_grant, w_grant_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic [1:0] w_pick;
  logic       w_req;
  logic       w_busy;

  logic [sdram_depth-1:0] w_adr [4];
  logic [3:0]             w_sel [4];
  logic [31:0]            w_di  [4];

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign w_adr[i] = fml.m_adr[i*sdram_depth +: sdram_depth];
    assign w_sel[i] = fml.m_sel[i*4 +: 4];
    assign w_di[i]  = fml.m_di[i*32 +: 32];
  end

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    w_pick = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (fml.m_stb[r_ptr + 2'(i)]) w_pick = r_ptr + 2'(i);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_grant <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (|fml.m_stb) begin
          w_grant_nxt = w_pick;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (fml.s_ack) begin
          w_state_nxt = BURST;
          w_cnt_nxt   = 2'd3;
        end else if (!fml.m_stb[r_grant]) begin
          // Master withdrew before the controller accepted: no rotation.
          w_state_nxt = IDLE;
        end
      end
      BURST: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_grant + 2'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_req  = (r_state == REQ);
  assign w_busy = (r_state != IDLE);

  assign fml.s_adr = w_adr[r_grant];
  assign fml.s_we  = fml.m_we[r_grant];
  assign fml.s_stb = w_req & fml.m_stb[r_grant];
  assign fml.m_ack = (w_req && fml.s_ack) ? (4'b0001 << r_grant) : 4'b0000;
  assign fml.s_sel = w_busy ? w_sel[r_grant] : 4'h0;
  assign fml.s_di  = w_busy ? w_di[r_grant]  : 32'h0;
  assign fml.m_do  = fml.s_do;

endmodule

// File: tb/tb_hpdmc_fmlarb.sv
// Directed bench for hpdmc_fmlarb: bench acts as the four masters and the hpdmc.
// Inputs change 1 time unit after the rising edge; outputs are checked after that.
module tb_hpdmc_fmlarb;
  localparam int D = 26;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  logic [D-1:0] tadr [4];
  logic [31:0]  tdi  [4];
  logic [3:0]   tsel [4];
  logic [3:0]   twe;

  hpdmc_fmlarb_if #(.sdram_depth(D)) bus ();

  hpdmc_fmlarb #(.sdram_depth(D)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .fml       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.m_stb  = 4'b0000;
    bus.s_ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Entered in IDLE with requests present; leaves in the IDLE cycle after BURST.
  task automatic run_burst(input int g, input int ack_dly, input bit drop);
    @(posedge clk); #1;
    check($sformatf("req%0d_stb", g), bus.s_stb, 1);
    check($sformatf("req%0d_adr", g), bus.s_adr, tadr[g]);
    check($sformatf("req%0d_we", g), bus.s_we, twe[g]);
    check($sformatf("req%0d_sel", g), bus.s_sel, tsel[g]);
    check($sformatf("req%0d_noack", g), bus.m_ack, 0);
    repeat (ack_dly) begin
      @(posedge clk); #1;
      check($sformatf("wait%0d_stb", g), bus.s_stb, 1);
      check($sformatf("wait%0d_noack", g), bus.m_ack, 0);
    end
    bus.s_ack = 1'b1;
    bus.s_do  = 32'h1234_0000 | g;
    #1;
    check($sformatf("ack%0d_mack", g), bus.m_ack, 4'b0001 << g);
    check($sformatf("ack%0d_di", g), bus.s_di, tdi[g]);
    check($sformatf("ack%0d_mdo", g), bus.m_do, 32'h1234_0000 | g);
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      bus.s_ack = 1'b0;
      if (drop) bus.m_stb[g] = 1'b0;
      #1;
      check($sformatf("burst%0d_%0d_stb", g, b), bus.s_stb, 0);
      check($sformatf("burst%0d_%0d_mack", g, b), bus.m_ack, 0);
      check($sformatf("burst%0d_%0d_di", g, b), bus.s_di, tdi[g]);
    end
    @(posedge clk); #1;
    check($sformatf("dead%0d_stb", g), bus.s_stb, 0);
    check($sformatf("dead%0d_sel", g), bus.s_sel, 0);
    check($sformatf("dead%0d_di", g), bus.s_di, 0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    tadr[0] = 26'h0000040; tadr[1] = 26'h0000080; tadr[2] = 26'h0000100; tadr[3] = 26'h3FFFFC0;
    tdi[0]  = 32'hA0A0_0000; tdi[1] = 32'hB1B1_1111; tdi[2] = 32'hC2C2_2222; tdi[3] = 32'hD3D3_3333;
    tsel[0] = 4'h1; tsel[1] = 4'h3; tsel[2] = 4'hF; tsel[3] = 4'h8;
    twe     = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      bus.m_adr[i*D +: D]  = tadr[i];
      bus.m_di[i*32 +: 32] = tdi[i];
      bus.m_sel[i*4 +: 4]  = tsel[i];
    end
    bus.m_we  = twe;
    bus.m_stb = 4'b0000;
    bus.s_ack = 1'b0;
    bus.s_do  = 32'h0;
    rst_n     = 1'b0;

    // Reset state
    #1;
    check("rst_stb", bus.s_stb, 0);
    check("rst_mack", bus.m_ack, 0);
    check("rst_adr", bus.s_adr, tadr[0]);
    check("rst_we", bus.s_we, twe[0]);
    check("rst_sel", bus.s_sel, 0);
    check("rst_di", bus.s_di, 0);

    // Single write from master 2, ack two cycles after s_stb rises
    do_reset();
    bus.m_stb = 4'b0100;
    #1;
    check("idle_stb", bus.s_stb, 0);
    run_burst(2, 2, 1'b1);

    // Read broadcast in IDLE
    bus.s_do = 32'hDEADBEEF;
    #1;
    check("bcast_mdo", bus.m_do, 32'hDEADBEEF);

    // All four request from reset: strict 0,1,2,3 order
    do_reset();
    bus.m_stb = 4'b1111;
    for (int g = 0; g < 4; g++) run_burst(g, 1, 1'b1);

    // Master 0 streams, master 3 asks once: 0,3,0
    do_reset();
    bus.m_stb = 4'b1001;
    run_burst(0, 1, 1'b0);
    run_burst(3, 0, 1'b1);
    run_burst(0, 0, 1'b0);

    // Abort: master 1 withdraws before ack, pointer must stay at 0
    do_reset();
    bus.m_stb = 4'b0010;
    @(posedge clk); #1;
    check("abort_req_stb", bus.s_stb, 1);
    check("abort_req_adr", bus.s_adr, tadr[1]);
    bus.m_stb = 4'b0000;
    #1;
    check("abort_drop_stb", bus.s_stb, 0);
    check("abort_drop_mack", bus.m_ack, 0);
    @(posedge clk); #1;
    check("abort_idle_sel", bus.s_sel, 0);
    check("abort_idle_mack", bus.m_ack, 0);
    bus.m_stb = 4'b1011;
    @(posedge clk); #1;
    check("abort_next_adr", bus.s_adr, tadr[0]);
    check("abort_next_stb", bus.s_stb, 1);

    // Reset mid-burst after the pointer has moved to 3
    do_reset();
    bus.m_stb = 4'b0100;
    run_burst(2, 0, 1'b1);
    bus.m_stb = 4'b1000;
    @(posedge clk); #1;
    check("mid_req_adr", bus.s_adr, tadr[3]);
    bus.s_ack = 1'b1;
    #1;
    check("mid_ack", bus.m_ack, 4'b1000);
    @(posedge clk); #1;
    bus.s_ack = 1'b0;
    bus.m_stb = 4'b0000;
    #1;
    check("mid_beat2_di", bus.s_di, tdi[3]);
    rst_n = 1'b0;
    bus.m_stb = 4'b1010;
    #1;
    check("mid_rst_stb", bus.s_stb, 0);
    check("mid_rst_sel", bus.s_sel, 0);
    check("mid_rst_di", bus.s_di, 0);
    check("mid_rst_mack", bus.m_ack, 0);
    check("mid_rst_adr", bus.s_adr, tadr[0]);
    @(posedge clk); #1;
    check("mid_hold_stb", bus.s_stb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_after_adr", bus.s_adr, tadr[1]);
    check("mid_after_stb", bus.s_stb, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
